// File: rtl/up_datapath_unit.sv
// ---------------------------------------------------------------------------
// up_datapath_unit
// 8-bit datapath of the "up" microprocessor core. It holds a 4-entry register
// bank, the ALU with its operand muxes, the program counter (PC), the stack
// pointer (SP) and the 4-bit instruction register (IR). The external control
// unit steers every cycle through selects, the ALU opcode and write strobes.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   nRst           : synchronous reset, ACTIVE-HIGH despite its legacy name
//   data_in        : memory/bus read data
//   rb_sel_data_in : register write source (0 = ALU result, 1 = data_in)
//   a_sel_in_a     : ALU operand A source (0 = rb[rb_sel_out_a], 1 = PC)
//   a_sel_in_b     : ALU operand B source (0 = rb[rb_sel_out_b], 1 = SP)
//   a_op           : ALU operation
//   ir_we          : IR load strobe (IR <= data_in[top nibble])
//   pc_we          : PC load strobe (PC <= ALU result)
//   rb_sel_out_a   : register read port A address
//   rb_sel_out_b   : register read port B address
//   rb_sel_in      : register write address
//   rb_we          : register write strobe
//   sp_we          : SP load strobe (SP <= ALU result)
//   data_out       : combinational ALU result (data/address output)
//   ir             : instruction register contents
//   flags          : {Z,N,C,V}, only present when UP_DATAPATH_FLAGS_EN is defined
//
// Optional feature macro: UP_DATAPATH_FLAGS_EN (adds the registered flags port).
// ---------------------------------------------------------------------------
module up_datapath_unit #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] SP_RESET = 8'hFF
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rb_sel_data_in,
    input  logic             a_sel_in_a,
    input  logic             a_sel_in_b,
    input  logic [3:0]       a_op,
    input  logic             ir_we,
    input  logic             pc_we,
    input  logic [1:0]       rb_sel_out_a,
    input  logic [1:0]       rb_sel_out_b,
    input  logic [1:0]       rb_sel_in,
    input  logic             rb_we,
    input  logic             sp_we,
    output logic [WIDTH-1:0] data_out,
    output logic [3:0]       ir
`ifdef UP_DATAPATH_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int              MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    localparam logic [3:0] OP_PASS_A = 4'd0;
    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] OP_OR     = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_NOT    = 4'd6;
    localparam logic [3:0] OP_INC    = 4'd7;
    localparam logic [3:0] OP_DEC    = 4'd8;
    localparam logic [3:0] OP_SHL    = 4'd9;
    localparam logic [3:0] OP_SHR    = 4'd10;
    localparam logic [3:0] OP_ASR    = 4'd11;
    localparam logic [3:0] OP_ROL    = 4'd12;
    localparam logic [3:0] OP_ROR    = 4'd13;
    localparam logic [3:0] OP_PASS_B = 4'd14;
    localparam logic [3:0] OP_ZERO   = 4'd15;

    logic [WIDTH-1:0] rb [4];
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] sp;
    logic [3:0]       ir_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_out;

    // Operand muxes read the registers combinationally, so a register written
    // this edge still supplies its old value to the ALU (no bypass).
    assign op_a = a_sel_in_a ? pc : rb[rb_sel_out_a];
    assign op_b = a_sel_in_b ? sp : rb[rb_sel_out_b];

    always_comb begin
        alu_out = '0;
        case (a_op)
            OP_PASS_A: alu_out = op_a;
            OP_ADD:    alu_out = op_a + op_b;
            OP_SUB:    alu_out = op_a - op_b;
            OP_AND:    alu_out = op_a & op_b;
            OP_OR:     alu_out = op_a | op_b;
            OP_XOR:    alu_out = op_a ^ op_b;
            OP_NOT:    alu_out = ~op_a;
            OP_INC:    alu_out = op_a + ONE;
            OP_DEC:    alu_out = op_a - ONE;
            OP_SHL:    alu_out = {op_a[MSB-1:0], 1'b0};
            OP_SHR:    alu_out = {1'b0, op_a[MSB:1]};
            OP_ASR:    alu_out = {op_a[MSB], op_a[MSB:1]};
            OP_ROL:    alu_out = {op_a[MSB-1:0], op_a[MSB]};
            OP_ROR:    alu_out = {op_a[0], op_a[MSB:1]};
            OP_PASS_B: alu_out = op_b;
            OP_ZERO:   alu_out = '0;
            default:   alu_out = '0;
        endcase
    end

    assign data_out = alu_out;
    assign ir       = ir_q;

    // All destinations sample the same pre-edge alu_out/data_in, so any mix
    // of strobes in one cycle loads a consistent value everywhere.
    always_ff @(posedge clk) begin
        if (nRst) begin
            for (int i = 0; i < 4; i++) rb[i] <= '0;
            pc   <= '0;
            sp   <= SP_RESET;
            ir_q <= '0;
        end else begin
            if (rb_we) rb[rb_sel_in] <= rb_sel_data_in ? data_in : alu_out;
            if (pc_we) pc <= alu_out;
            if (sp_we) sp <= alu_out;
            if (ir_we) ir_q <= data_in[MSB:MSB-3];
        end
    end

`ifdef UP_DATAPATH_FLAGS_EN
    logic             flag_c;
    logic             flag_v;
    logic [WIDTH:0]   sum_ext;
    logic             flags_upd;

    always_comb begin
        flag_c  = 1'b0;
        flag_v  = 1'b0;
        sum_ext = {1'b0, op_a} + {1'b0, op_b};
        case (a_op)
            OP_ADD: begin
                flag_c = sum_ext[WIDTH];
                flag_v = (op_a[MSB] == op_b[MSB]) && (alu_out[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                flag_c = (op_a < op_b);
                flag_v = (op_a[MSB] != op_b[MSB]) && (alu_out[MSB] != op_a[MSB]);
            end
            OP_INC: begin
                flag_c = &op_a;
                flag_v = ~op_a[MSB] & alu_out[MSB];
            end
            OP_DEC: begin
                flag_c = (op_a == '0);
                flag_v = op_a[MSB] & ~alu_out[MSB];
            end
            OP_SHL, OP_ROL:         flag_c = op_a[MSB];
            OP_SHR, OP_ASR, OP_ROR: flag_c = op_a[0];
            default: begin
                flag_c = 1'b0;
                flag_v = 1'b0;
            end
        endcase
    end

    // Flags track only ALU results that actually get stored somewhere.
    assign flags_upd = (rb_we & ~rb_sel_data_in) | pc_we | sp_we;

    always_ff @(posedge clk) begin
        if (nRst) begin
            flags <= 4'b0000;
        end else if (flags_upd) begin
            flags <= {(alu_out == '0), alu_out[MSB], flag_c, flag_v};
        end
    end
`endif

endmodule

// File: tb/tb_up_datapath_unit.sv
// ---------------------------------------------------------------------------
// tb_up_datapath_unit
// Directed bench for up_datapath_unit. Inputs change 1 time unit after a
// rising edge; outputs are checked 1 time unit later, well away from edges.
// Register, PC and SP contents are observed through the ALU pass paths.
// ---------------------------------------------------------------------------
module tb_up_datapath_unit;

    logic       clk;
    logic       nRst;
    logic [7:0] data_in;
    logic       rb_sel_data_in;
    logic       a_sel_in_a;
    logic       a_sel_in_b;
    logic [3:0] a_op;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] rb_sel_out_a;
    logic [1:0] rb_sel_out_b;
    logic [1:0] rb_sel_in;
    logic       rb_we;
    logic       sp_we;
    logic [7:0] data_out;
    logic [3:0] ir;
`ifdef UP_DATAPATH_FLAGS_EN
    logic [3:0] flags;
`endif

    int total = 0;
    int bad   = 0;

    up_datapath_unit dut (
        .clk            (clk),
        .nRst           (nRst),
        .data_in        (data_in),
        .rb_sel_data_in (rb_sel_data_in),
        .a_sel_in_a     (a_sel_in_a),
        .a_sel_in_b     (a_sel_in_b),
        .a_op           (a_op),
        .ir_we          (ir_we),
        .pc_we          (pc_we),
        .rb_sel_out_a   (rb_sel_out_a),
        .rb_sel_out_b   (rb_sel_out_b),
        .rb_sel_in      (rb_sel_in),
        .rb_we          (rb_we),
        .sp_we          (sp_we),
        .data_out       (data_out),
        .ir             (ir)
`ifdef UP_DATAPATH_FLAGS_EN
        ,
        .flags          (flags)
`endif
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rb_we = 1'b0; pc_we = 1'b0; sp_we = 1'b0; ir_we = 1'b0;
        rb_sel_data_in = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_data(input logic [1:0] idx, input logic [7:0] val);
        idle();
        rb_sel_in = idx; rb_sel_data_in = 1'b1; data_in = val; rb_we = 1'b1;
        tick();
        idle();
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        idle();
        a_sel_in_a = 1'b0; rb_sel_out_a = idx; a_op = 4'd0;
        #1;
        check(tag, data_out, exp);
    endtask

    task automatic chk_op(input string tag, input logic [3:0] op, input logic [7:0] exp);
        a_op = op;
        #1;
        check(tag, data_out, exp);
    endtask

    task automatic chk_pc(input string tag, input logic [7:0] exp);
        idle();
        a_sel_in_a = 1'b1; a_op = 4'd0;
        #1;
        check(tag, data_out, exp);
        a_sel_in_a = 1'b0;
    endtask

    task automatic chk_sp(input string tag, input logic [7:0] exp);
        idle();
        a_sel_in_b = 1'b1; a_op = 4'd14;
        #1;
        check(tag, data_out, exp);
        a_sel_in_b = 1'b0;
    endtask

    task automatic chk_all_reset(input string tag);
        chk_reg({tag, "_r0"}, 2'd0, 8'h00);
        chk_reg({tag, "_r1"}, 2'd1, 8'h00);
        chk_reg({tag, "_r2"}, 2'd2, 8'h00);
        chk_reg({tag, "_r3"}, 2'd3, 8'h00);
        chk_pc({tag, "_pc"}, 8'h00);
        chk_sp({tag, "_sp"}, 8'hFF);
        check({tag, "_ir"}, {4'h0, ir}, 8'h00);
    endtask

    // Directed stimulus sequence
    initial begin
        nRst = 1'b1; data_in = 8'h00;
        a_sel_in_a = 1'b0; a_sel_in_b = 1'b0; a_op = 4'd0;
        rb_sel_out_a = 2'd0; rb_sel_out_b = 2'd0; rb_sel_in = 2'd0;
        idle();

        // 1. Reset
        tick();
        tick();
        check("rst_data_out_in_reset", data_out, 8'h00);
        nRst = 1'b0;
        chk_all_reset("rst");
`ifdef UP_DATAPATH_FLAGS_EN
        check("rst_flags", {4'h0, flags}, 8'h00);
`endif

        // 2. Load and add, then the rest of the ALU table on 12/34
        wr_data(2'd1, 8'h12);
        wr_data(2'd2, 8'h34);
        rb_sel_out_a = 2'd1; rb_sel_out_b = 2'd2;
        chk_op("add_12_34", 4'd1, 8'h46);
        rb_sel_data_in = 1'b0; rb_sel_in = 2'd3; rb_we = 1'b1;
        tick();
        chk_reg("r3_after_add_wr", 2'd3, 8'h46);
        rb_sel_out_a = 2'd1; rb_sel_out_b = 2'd2;
        chk_op("sub_12_34",  4'd2,  8'hDE);
        chk_op("and_12_34",  4'd3,  8'h10);
        chk_op("or_12_34",   4'd4,  8'h36);
        chk_op("xor_12_34",  4'd5,  8'h26);
        chk_op("not_12",     4'd6,  8'hED);
        chk_op("inc_12",     4'd7,  8'h13);
        chk_op("dec_12",     4'd8,  8'h11);
        chk_op("passb_34",   4'd14, 8'h34);
        chk_op("zero",       4'd15, 8'h00);

        // Shifts/rotates on 85 and 05
        wr_data(2'd0, 8'h85);
        rb_sel_out_a = 2'd0;
        chk_op("shl_85", 4'd9,  8'h0A);
        chk_op("shr_85", 4'd10, 8'h42);
        chk_op("asr_85", 4'd11, 8'hC2);
        chk_op("rol_85", 4'd12, 8'h0B);
        chk_op("ror_85", 4'd13, 8'hC2);
        wr_data(2'd0, 8'h05);
        rb_sel_out_a = 2'd0;
        chk_op("ror_05", 4'd13, 8'h82);
        chk_op("asr_05", 4'd11, 8'h02);

        // 3. Wrap / borrow
        wr_data(2'd1, 8'hFF);
        wr_data(2'd2, 8'h01);
        rb_sel_out_a = 2'd1; rb_sel_out_b = 2'd2;
        chk_op("add_wrap", 4'd1, 8'h00);
        rb_sel_out_a = 2'd2; rb_sel_out_b = 2'd1;
        chk_op("sub_borrow", 4'd2, 8'h02);
        rb_sel_out_a = 2'd1; rb_sel_out_b = 2'd2; a_op = 4'd1;
        rb_sel_data_in = 1'b0; rb_sel_in = 2'd0; rb_we = 1'b1;
        tick();
        idle();
        chk_reg("r0_after_wrap_wr", 2'd0, 8'h00);
`ifdef UP_DATAPATH_FLAGS_EN
        check("flags_add_wrap", {4'h0, flags}, 8'h0A);
`endif

        // 4. PC increment: pre-edge result is PC+1
        idle();
        a_sel_in_a = 1'b1; a_op = 4'd7; pc_we = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check($sformatf("pc_inc_%0d", i), data_out, 8'(i));
            tick();
        end
        chk_pc("pc_is_3", 8'h03);
        tick();
        chk_pc("pc_holds_3", 8'h03);

        // 5. SP load from a register, then IR
        wr_data(2'd2, 8'hFE);
        a_sel_in_b = 1'b0; rb_sel_out_b = 2'd2; a_op = 4'd14; sp_we = 1'b1;
        tick();
        chk_sp("sp_fe", 8'hFE);
        data_in = 8'hA5; ir_we = 1'b1;
        tick();
        check("ir_load_a", {4'h0, ir}, 8'h0A);
        ir_we = 1'b0; data_in = 8'h3C;
        tick();
        check("ir_hold_a", {4'h0, ir}, 8'h0A);

        // Simultaneous pc_we + rb_we with A = PC (PC=3 -> both get 4)
        idle();
        a_sel_in_a = 1'b1; a_op = 4'd7;
        pc_we = 1'b1; rb_we = 1'b1; rb_sel_data_in = 1'b0; rb_sel_in = 2'd1;
        tick();
        chk_pc("pc_dual_wr", 8'h04);
        chk_reg("r1_dual_wr", 2'd1, 8'h04);

        // Same-register read during write: old value in, new value out
        idle();
        a_sel_in_a = 1'b0; rb_sel_out_a = 2'd1; a_op = 4'd7;
        rb_sel_in = 2'd1; rb_we = 1'b1;
        #1;
        check("rdw_old_in", data_out, 8'h05);
        tick();
        chk_reg("rdw_new_out", 2'd1, 8'h05);

        // 6. Mid-operation reset overrides every strobe
        idle();
        a_sel_in_a = 1'b1; a_op = 4'd7;
        nRst = 1'b1; data_in = 8'h77; rb_sel_data_in = 1'b1; rb_sel_in = 2'd3;
        rb_we = 1'b1; pc_we = 1'b1; sp_we = 1'b1; ir_we = 1'b1;
        tick();
        nRst = 1'b0;
        idle();
        chk_all_reset("midrst");
`ifdef UP_DATAPATH_FLAGS_EN
        check("midrst_flags", {4'h0, flags}, 8'h00);
`endif

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/up_datapath_unit.md
Name: up_datapath_unit

Overview:
8-bit datapath for the small microprocessor ("up") core. It contains a 4x8 register bank, an 8-bit ALU with operand muxes, an 8-bit program counter (PC), an 8-bit stack pointer (SP) and a 4-bit instruction register (IR). Every cycle is steered by the external control unit through select, opcode and write-enable strobes. The ALU result is the datapath's data/address output, and the IR opcode nibble is returned to the control unit.

Parameters:
WIDTH, 8, datapath word width; all arithmetic and register widths follow it. The test plan assumes 8.
SP_RESET, 8'hFF, stack pointer value after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge
nRst  in  1  reset; synchronous, active-high (1 = reset), despite the legacy name
data_in  in  8  memory/bus read data
rb_sel_data_in  in  1  register-bank write source: 0 = ALU result, 1 = data_in
a_sel_in_a  in  1  ALU operand A source: 0 = rb[rb_sel_out_a], 1 = PC
a_sel_in_b  in  1  ALU operand B source: 0 = rb[rb_sel_out_b], 1 = SP
a_op  in  4  ALU operation
ir_we  in  1  IR load strobe
pc_we  in  1  PC load strobe
rb_sel_out_a  in  2  register-bank read port A address
rb_sel_out_b  in  2  register-bank read port B address
rb_sel_in  in  2  register-bank write address
rb_we  in  1  register-bank write strobe
sp_we  in  1  SP load strobe
data_out  out  8  combinational ALU result
ir  out  4  instruction register contents

Behaviour:
- Reset (nRst=1 at a rising edge):
  - r0..r3 = 0, PC = 0, IR = 0, SP = SP_RESET.
  - Reset overrides every write strobe in the same cycle.
- Register bank:
  - Two combinational read ports.
  - One write port: on a clk edge with rb_we=1, rb[rb_sel_in] <= (rb_sel_data_in ? data_in : alu_out).
  - No write-to-read bypass: a read in the write cycle returns the old value.
- ALU:
  - Purely combinational. A and B come from the operand muxes; the result is 8 bits and wraps modulo 256.
  - a_op encoding:
    - 0 PASS A
    - 1 A+B
    - 2 A-B
    - 3 A&B
    - 4 A|B
    - 5 A^B
    - 6 ~A
    - 7 A+1
    - 8 A-1
    - 9 A<<1 (LSB 0)
    - 10 A>>1 logical
    - 11 A>>>1 arithmetic
    - 12 rotate-left A
    - 13 rotate-right A
    - 14 PASS B
    - 15 constant 0
- data_out = alu_out at all times, including during reset.
- PC: on a clk edge with pc_we=1, PC <= alu_out; otherwise hold.
- SP: on a clk edge with sp_we=1, SP <= alu_out; otherwise hold.
- IR: on a clk edge with ir_we=1, IR <= data_in[7:4]; otherwise hold. ir reflects the IR register.
- Simultaneous strobes: all enabled destinations load in the same edge from the same pre-edge alu_out/data_in values. Examples:
  - pc_we plus rb_we with operand A = PC: both capture the same result.
  - Reading and writing the same register: old value in, new value out.
- Latency: 0 cycles from selects/op to data_out; 1 edge to any state register.
- All strobes inactive: no state changes.

Optional Feature:
- Macro UP_DATAPATH_FLAGS_EN.
- Defined:
  - Adds output port flags[3:0] = {Z,N,C,V}, registered and reset to 0.
  - Flags update on any edge where (rb_we & ~rb_sel_data_in) | pc_we | sp_we.
  - Z = (alu_out==0); N = alu_out[7].
  - C = carry-out for ADD/INC, borrow for SUB/DEC, shifted-out bit for shifts/rotates, 0 otherwise.
  - V = signed overflow for ADD/SUB/INC/DEC, 0 otherwise.
- Undefined: no flags port and no flag logic; all other behaviour identical.

Test Plan:
1. Reset:
   - Stimulus: nRst=1 for 2 edges, all strobes 0, a_op=0, a_sel_in_a=0.
   - Response: ir=0, r0..r3=0, PC=0, SP=8'hFF, data_out=0.
   - Then, with a_sel_in_b=1, a_op=14: data_out=8'hFF.
2. Load and add:
   - Stimulus: write data_in=8'h12 to r1 and data_in=8'h34 to r2 (rb_sel_data_in=1, rb_we=1).
   - Then rb_sel_out_a=1, rb_sel_out_b=2, a_op=1: data_out=8'h46.
   - Then write it to r3 (rb_sel_data_in=0): r3 reads 8'h46.
3. Wrap/borrow:
   - r1=8'hFF, r2=8'h01, a_op=1 -> data_out=8'h00.
   - a_op=2 with operands swapped (A=8'h01, B=8'hFF) -> data_out=8'h02.
   - With UP_DATAPATH_FLAGS_EN, the ADD case written to r0 -> flags Z=1, C=1.
4. PC increment:
   - Stimulus: a_sel_in_a=1, a_op=7, pc_we=1 for 3 edges.
   - Response: data_out steps 8'h01, 8'h02, 8'h03 after each edge (PC=3). pc_we=0 -> PC holds.
5. SP decrement and IR:
   - Stimulus: a_sel_in_b=1, a_op=14 shows SP; then SP <= SP-1 via rb read of a register holding 8'hFE with sp_we.
   - Response: data_out(PASS B)=8'hFE.
   - ir_we=1, data_in=8'hA5 -> ir=4'hA; ir_we=0, data_in=8'h3C -> ir stays 4'hA.
6. Mid-operation reset:
   - Stimulus: assert nRst together with rb_we/pc_we/sp_we/ir_we=1.
   - Response: all state returns to reset values, strobes ignored; same-register read-during-write returns the old value.
